// File: rtl/child_pkg.sv
// Shared constants and types for the child sprite motion controller.
package child_pkg;

  typedef logic signed [10:0] coord_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t;

  localparam int CHILD_HALF_W = 26;
  localparam int CHILD_HALF_H = 30;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;

  localparam coord_t X_START  = 11'sd320;
  localparam coord_t X_MIN    = 11'sd26;
  localparam coord_t X_MAX    = 11'sd613;
  localparam coord_t Y_MIN    = 11'sd30;
  localparam coord_t Y_GROUND = 11'sd449;
  localparam coord_t X_STEP   = 11'sd2;

  localparam logic [4:0] JUMP_V0 = 5'd8;
  localparam logic [4:0] GRAVITY = 5'd1;
  localparam logic [4:0] VMAX    = 5'd12;

  function automatic coord_t to_coord(input logic [9:0] v);
    return coord_t'({1'b0, v});
  endfunction

endpackage

// File: rtl/child_motion_frame_tick_gen.sv
// Frame tick generator: registers vsync and flags its falling edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  // Resetting to 0 suppresses a false edge when reset releases with vsync low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) vsync_q <= 1'b0;
    else          vsync_q <= vsync;
  end

  assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/child_motion.sv
// Per-frame motion controller for the child sprite.
// Build macro CHILD_JUMP_EN enables the jump/gravity FSM; otherwise W/S step y.
//   state  | meaning
//   GROUND | standing on ground, W starts a jump
//   RISE   | moving up, vy decreasing
//   FALL   | moving down, vy increasing to VMAX
module child_motion
  import child_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vsync,
  input  logic [7:0] keycode,
  output logic [9:0] centerx,
  output logic [9:0] centery,
  output logic       airborne,
  output logic       update_strobe
);

  logic       tick;
  coord_t     x_cur, y_cur, x_left, x_right;
  logic [9:0] x_next, y_next;

  frame_tick_gen u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .vsync   (vsync),
    .tick    (tick)
  );

  assign x_cur   = to_coord(centerx);
  assign y_cur   = to_coord(centery);
  assign x_left  = x_cur - X_STEP;
  assign x_right = x_cur + X_STEP;

  always_comb begin
    x_next = centerx;
    if (keycode == KEY_A)      x_next = (x_left < X_MIN)  ? X_MIN[9:0] : x_left[9:0];
    else if (keycode == KEY_D) x_next = (x_right > X_MAX) ? X_MAX[9:0] : x_right[9:0];
  end

`ifdef CHILD_JUMP_EN
  motion_state_t state, state_next;
  logic [4:0]    vy, vy_next, vy_dec, vy_inc;
  coord_t        vy_c, y_up, y_dn;

  assign vy_c   = coord_t'({6'd0, vy});
  assign y_up   = y_cur - vy_c;
  assign y_dn   = y_cur + vy_c;
  assign vy_dec = vy - GRAVITY;
  assign vy_inc = vy + GRAVITY;

  always_comb begin
    state_next = state;
    vy_next    = vy;
    y_next     = centery;
    case (state)
      GROUND: begin
        if (keycode == KEY_W) begin
          y_next     = centery - {5'd0, JUMP_V0};
          vy_next    = JUMP_V0 - GRAVITY;
          state_next = RISE;
        end
      end
      RISE: begin
        if (y_up < Y_MIN) begin
          y_next     = Y_MIN[9:0];
          vy_next    = '0;
          state_next = FALL;
        end else begin
          y_next  = y_up[9:0];
          vy_next = vy_dec;
          if (vy_dec == '0) state_next = FALL;
        end
      end
      FALL: begin
        if (y_dn >= Y_GROUND) begin
          y_next     = Y_GROUND[9:0];
          vy_next    = '0;
          state_next = GROUND;
        end else begin
          y_next  = y_dn[9:0];
          vy_next = (vy_inc > VMAX) ? VMAX : vy_inc;
        end
      end
      default: begin
        vy_next    = '0;
        state_next = GROUND;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= GROUND;
      vy    <= '0;
    end else if (tick) begin
      state <= state_next;
      vy    <= vy_next;
    end
  end

  assign airborne = (state != GROUND);
`else
  coord_t y_up, y_dn;

  assign y_up = y_cur - X_STEP;
  assign y_dn = y_cur + X_STEP;

  always_comb begin
    y_next = centery;
    if (keycode == KEY_W)      y_next = (y_up < Y_MIN)    ? Y_MIN[9:0]    : y_up[9:0];
    else if (keycode == KEY_S) y_next = (y_dn > Y_GROUND) ? Y_GROUND[9:0] : y_dn[9:0];
  end

  assign airborne = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      centerx       <= X_START[9:0];
      centery       <= Y_GROUND[9:0];
      update_strobe <= 1'b0;
    end else begin
      update_strobe <= tick;
      if (tick) begin
        centerx <= x_next;
        centery <= y_next;
      end
    end
  end

endmodule
